// File: rtl/mc_dual_buffer_pkg.sv
// mc_dual_buffer_pkg
// Shared types and constants for the multi-channel ping-pong capture buffer.
//   state_e       : capture FSM state (encoding is visible on state_o)
//   StateW        : width of the state encoding
//   ReadStateAddr : FSMC address of the READ_STATE register driving rd_lock

package mc_dual_buffer_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StWaitTrig = 2'd0,
    StFill     = 2'd1,
    StHold     = 2'd2
  } state_e;

  localparam logic [15:0] ReadStateAddr = 16'h4000;

endpackage

// File: rtl/mc_dual_buffer_if.sv
// mc_dual_buffer_if
// Bundle of the capture, reader-control and status signals of mc_dual_buffer.
//   master : acquisition/MCU side (drives wr_*, trig, rd_lock, rd_en/ch/addr)
//   slave  : the buffer itself (drives rd_data, rd_valid and the status outputs)
// Parameters must match those given to mc_dual_buffer.

interface mc_dual_buffer_if #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned CH_NUM     = 2
) ();
  import mc_dual_buffer_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  // Capture side
  logic                         wr_en;
  logic [CH_NUM*DATA_WIDTH-1:0] wr_data;
  logic                         trig;
  // Reader control
  logic                         rd_lock;
  logic                         rd_en;
  logic [CH_W-1:0]              rd_ch;
  logic [PTR_W-1:0]             rd_addr;
  // Read data and status
  logic [15:0]                  rd_data;
  logic                         rd_valid;
  logic                         has_switched;
  logic                         write_buf;
  logic [PTR_W-1:0]             write_ptr;
  logic [15:0]                  overrun_cnt;
  logic [StateW-1:0]            state_o;

  modport master (
    output wr_en, wr_data, trig, rd_lock, rd_en, rd_ch, rd_addr,
    input  rd_data, rd_valid, has_switched, write_buf, write_ptr, overrun_cnt, state_o
  );

  modport slave (
    input  wr_en, wr_data, trig, rd_lock, rd_en, rd_ch, rd_addr,
    output rd_data, rd_valid, has_switched, write_buf, write_ptr, overrun_cnt, state_o
  );

endinterface

// File: rtl/mc_dual_buffer_sdp_ram.sv
// mc_dual_buffer_sdp_ram
// Simple dual-port RAM (the sdp_ram block): one write port, one synchronous read port.
// Contents are not reset. The read register only updates when i_re is high, so
// o_rdata holds the last read value otherwise.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_re    : read enable
//   i_raddr : read address
//   o_rdata : read data, one cycle after i_re

module mc_dual_buffer_sdp_ram #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/mc_dual_buffer.sv
// mc_dual_buffer
// Multi-channel ping-pong capture buffer. After a trigger rising edge, CH_NUM
// parallel sample streams fill one bank of DEPTH samples per channel; the full
// bank is then handed to the reader and capture moves to the other bank. While
// the reader holds rd_lock the bank swap is deferred and incoming samples are
// counted as overruns.
//
// Ports:
//   clk : system clock
//   rst : asynchronous active-high reset
//   bus : mc_dual_buffer_if.slave
//         wr_en/wr_data    sample strobe and packed channel data
//         trig             capture trigger (rising edge)
//         rd_lock          reader busy; blocks swaps, clears has_switched
//         rd_en/ch/addr    read request, answered one cycle later
//         rd_data/valid    zero-extended sample and its valid pulse
//         has_switched     a full bank is ready for reading
//         write_buf        bank currently being written
//         write_ptr        next write index
//         overrun_cnt      samples dropped while blocked (saturating)
//         state_o          FSM state
//
// Build option: define MC_DUAL_BUFFER_AUTO_REARM_EN to restart filling straight
// after each swap (gapless capture); otherwise each fill waits for a new trigger.
// Constraints: DATA_WIDTH <= 16, DEPTH a power of 2 and >= 4, CH_NUM in 1..8.

module mc_dual_buffer
  import mc_dual_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned CH_NUM     = 2
) (
  input  logic            clk,
  input  logic            rst,
  mc_dual_buffer_if.slave bus
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int unsigned RAM_AW = PTR_W + 1;

`ifdef MC_DUAL_BUFFER_AUTO_REARM_EN
  localparam state_e AfterSwap = StFill;
`else
  localparam state_e AfterSwap = StWaitTrig;
`endif

  // Capture FSM and status registers
  state_e           r_state;
  logic             r_trig_d;
  logic             r_write_buf;
  logic [PTR_W-1:0] r_write_ptr;
  logic             r_has_switched;
  logic [15:0]      r_overrun_cnt;

  // Read-side registers
  logic             r_rd_valid;
  logic [CH_W-1:0]  r_rd_ch;
  logic             r_rd_ok;

  logic                  w_trig_rise;
  logic                  w_last;
  logic                  w_wr_fire;
  logic [RAM_AW-1:0]     w_waddr;
  logic [RAM_AW-1:0]     w_raddr;
  logic [DATA_WIDTH-1:0] w_ram_q [CH_NUM];
  logic [DATA_WIDTH-1:0] w_sel;

  assign w_trig_rise = bus.trig & ~r_trig_d;
  assign w_last      = (r_write_ptr == PTR_W'(DEPTH - 1));
  assign w_wr_fire   = (r_state == StFill) && bus.wr_en;
  // Bank select is the RAM address MSB; reads always target the bank not being written.
  assign w_waddr     = {r_write_buf, r_write_ptr};
  assign w_raddr     = {~r_write_buf, bus.rd_addr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StWaitTrig;
      r_trig_d       <= 1'b0;
      r_write_buf    <= 1'b0;
      r_write_ptr    <= '0;
      r_has_switched <= 1'b0;
      r_overrun_cnt  <= '0;
    end else begin
      r_trig_d <= bus.trig;
      // A swap needs rd_lock low, so this never collides with the set below.
      if (bus.rd_lock) begin
        r_has_switched <= 1'b0;
      end
      unique case (r_state)
        StWaitTrig: begin
          if (w_trig_rise) begin
            r_state     <= StFill;
            r_write_ptr <= '0;
          end
        end
        StFill: begin
          if (bus.wr_en) begin
            if (w_last) begin
              // The final sample is stored either way; the lock only defers the swap.
              if (bus.rd_lock) begin
                r_state <= StHold;
              end else begin
                r_write_buf    <= ~r_write_buf;
                r_has_switched <= 1'b1;
                r_write_ptr    <= '0;
                r_state        <= AfterSwap;
              end
            end else begin
              r_write_ptr <= r_write_ptr + PTR_W'(1);
            end
          end
        end
        StHold: begin
          if (bus.wr_en && (r_overrun_cnt != 16'hFFFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 16'd1;
          end
          if (!bus.rd_lock) begin
            r_write_buf    <= ~r_write_buf;
            r_has_switched <= 1'b1;
            r_write_ptr    <= '0;
            r_state        <= AfterSwap;
          end
        end
        default: begin
          r_state <= StWaitTrig;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_ch    <= '0;
      r_rd_ok    <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      // Channel select is only captured on a read so rd_data holds between reads.
      if (bus.rd_en) begin
        r_rd_ch <= bus.rd_ch;
        r_rd_ok <= (32'(bus.rd_ch) < CH_NUM);
      end
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    mc_dual_buffer_sdp_ram #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (2 * DEPTH),
      .ADDR_W(RAM_AW)
    ) u_ram (
      .clk    (clk),
      .i_we   (w_wr_fire),
      .i_waddr(w_waddr),
      .i_wdata(bus.wr_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .i_re   (bus.rd_en),
      .i_raddr(w_raddr),
      .o_rdata(w_ram_q[k])
    );
  end

  always_comb begin
    w_sel = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (r_rd_ch == CH_W'(k)) begin
        w_sel = w_ram_q[k];
      end
    end
  end

  assign bus.rd_data      = r_rd_ok ? 16'(w_sel) : 16'h0000;
  assign bus.rd_valid     = r_rd_valid;
  assign bus.has_switched = r_has_switched;
  assign bus.write_buf    = r_write_buf;
  assign bus.write_ptr    = r_write_ptr;
  assign bus.overrun_cnt  = r_overrun_cnt;
  assign bus.state_o      = r_state;

endmodule
